// File: rtl/conf_spi_master.sv
`default_nettype none
// ============================================================================
// Module : conf_spi_master
// Brief  : Host-side SPI (mode 0) master for the channel configuration port.
//          Sends one CONF_WR/CONF_RD command byte (dc=0), then CONF_BYTES
//          data bytes (dc=1) from a show-ahead source or collected from MISO.
// Rev    : 1.0  initial release
// ============================================================================
module conf_spi_master #(
    parameter int         CLK_DIV    = 2,
    parameter int         CONF_BYTES = 8,
    parameter logic [7:0] WR_CMD     = 8'h2A,
    parameter logic [7:0] RD_CMD     = 8'h2D
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_vld_i,
    input  logic       cmd_rw_i,
    output logic       cmd_rdy_o,
    output logic       tx_byte_rd_o,
    input  logic [7:0] tx_byte_i,
    output logic       rx_byte_vld_o,
    output logic [7:0] rx_byte_o,
    output logic       done_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    output logic       spi_cs_n_o,
    input  logic       spi_miso_i,
    output logic       dc_o
);

    localparam int                 c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int                 c_byte_w  = $clog2(CONF_BYTES + 1);
    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_byte_w-1:0] c_byte_last = c_byte_w'(CONF_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_CMD   = 3'd2,
        S_DATA  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_div_w-1:0]  r_div;
    logic                r_phase;     // 0 = sclk low half, 1 = sclk high half
    logic [2:0]          r_bit;
    logic [c_byte_w-1:0] r_byte;
    logic                r_rw;
    logic [7:0]          r_tx_sr;
    logic [7:0]          r_rx_sr;

    logic       r_cmd_rdy;
    logic       r_tx_rd;
    logic       r_rx_vld;
    logic [7:0] r_rx_byte;
    logic       r_done;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_cs_n;
    logic       r_dc;

    logic       w_div_end;
    logic [7:0] w_cmd_byte;
    logic       w_rd_data;

    assign w_div_end  = (r_div == c_div_last);
    assign w_cmd_byte = r_rw ? RD_CMD : WR_CMD;
    assign w_rd_data  = (r_state == S_DATA) && r_rw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_phase   <= 1'b0;
            r_bit     <= 3'd7;
            r_byte    <= '0;
            r_rw      <= 1'b0;
            r_tx_sr   <= 8'h00;
            r_rx_sr   <= 8'h00;
            r_cmd_rdy <= 1'b1;
            r_tx_rd   <= 1'b0;
            r_rx_vld  <= 1'b0;
            r_rx_byte <= 8'h00;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_dc      <= 1'b0;
        end else begin
            r_tx_rd  <= 1'b0;
            r_rx_vld <= 1'b0;
            r_done   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd_vld_i && r_cmd_rdy) begin
                        r_rw      <= cmd_rw_i;
                        r_cs_n    <= 1'b0;
                        r_cmd_rdy <= 1'b0;
                        r_div     <= '0;
                        r_state   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_phase <= 1'b0;
                        r_bit   <= 3'd7;
                        r_mosi  <= w_cmd_byte[7];
                        r_tx_sr <= {w_cmd_byte[6:0], 1'b0};
                        r_state <= S_CMD;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_CMD, S_DATA: begin
                    // The payload byte only arrives in the first low cycle of
                    // bit 7, so its MSB reaches mosi one cycle into that phase.
                    if (r_tx_rd) begin
                        r_tx_sr <= {tx_byte_i[6:0], 1'b0};
                        r_mosi  <= tx_byte_i[7];
                    end
                    if (!w_div_end) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            r_sclk  <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            r_sclk  <= 1'b0;
                            r_rx_sr <= {r_rx_sr[6:0], spi_miso_i};
                            if (w_rd_data && (r_bit == 3'd0)) begin
                                r_rx_byte <= {r_rx_sr[6:0], spi_miso_i};
                                r_rx_vld  <= 1'b1;
                            end
                            if (r_bit != 3'd0) begin
                                r_bit   <= r_bit - 3'd1;
                                r_mosi  <= w_rd_data ? 1'b0 : r_tx_sr[7];
                                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                            end else if ((r_state == S_CMD) || (r_byte != c_byte_last)) begin
                                r_bit   <= 3'd7;
                                r_dc    <= 1'b1;
                                r_mosi  <= 1'b0;
                                r_tx_rd <= ~r_rw;
                                r_byte  <= (r_state == S_CMD) ? '0 : r_byte + 1'b1;
                                r_state <= S_DATA;
                            end else begin
                                r_dc    <= 1'b0;
                                r_mosi  <= 1'b0;
                                r_state <= S_HOLD;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    // Two divider periods with sclk parked low before releasing cs_n.
                    if (!w_div_end) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                        end else begin
                            r_phase   <= 1'b0;
                            r_cs_n    <= 1'b1;
                            r_done    <= 1'b1;
                            r_cmd_rdy <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_rdy_o     = r_cmd_rdy;
    assign tx_byte_rd_o  = r_tx_rd;
    assign rx_byte_vld_o = r_rx_vld;
    assign rx_byte_o     = r_rx_byte;
    assign done_o        = r_done;
    assign spi_sclk_o    = r_sclk;
    assign spi_mosi_o    = r_mosi;
    assign spi_cs_n_o    = r_cs_n;
    assign dc_o          = r_dc;

endmodule
`default_nettype wire

// File: tb/tb_conf_spi_master.sv
`default_nettype none
// ============================================================================
// Module : tb_conf_spi_master
// Brief  : Directed self-checking bench for conf_spi_master with a
//          slave/regfile model (CLK_DIV=2) and a timing monitor (CLK_DIV=3).
// Rev    : 1.0  initial release
// ============================================================================
module tb_conf_spi_master;

    localparam int c_n = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (CLK_DIV=2) ----------------
    logic       cmd_vld = 1'b0;
    logic       cmd_rw  = 1'b0;
    logic       cmd_rdy, tx_rd, rx_vld, done, sclk, mosi, cs_n, dc, miso;
    logic [7:0] rx_byte, tx_byte;
    int         tx_ptr = 0;
    logic       miso_r = 1'b0;

    assign tx_byte = 8'(tx_ptr + 1);
    assign miso    = miso_r;
    always @(posedge clk) if (tx_rd) tx_ptr <= tx_ptr + 1;

    conf_spi_master #(.CLK_DIV(2), .CONF_BYTES(c_n)) dut (
        .clk_i(clk), .rst_i(rst), .cmd_vld_i(cmd_vld), .cmd_rw_i(cmd_rw),
        .cmd_rdy_o(cmd_rdy), .tx_byte_rd_o(tx_rd), .tx_byte_i(tx_byte),
        .rx_byte_vld_o(rx_vld), .rx_byte_o(rx_byte), .done_o(done),
        .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_cs_n_o(cs_n),
        .spi_miso_i(miso), .dc_o(dc)
    );

    // ---------------- DUT B (CLK_DIV=3) ----------------
    logic       cmd_vld3 = 1'b0;
    logic       cmd_rdy3, tx_rd3, rx_vld3, done3, sclk3, mosi3, cs3, dc3;
    logic [7:0] rx_byte3;
    logic [7:0] tx3   = 8'hA5;
    logic       miso3 = 1'b0;

    conf_spi_master #(.CLK_DIV(3), .CONF_BYTES(c_n)) dut3 (
        .clk_i(clk), .rst_i(rst), .cmd_vld_i(cmd_vld3), .cmd_rw_i(1'b0),
        .cmd_rdy_o(cmd_rdy3), .tx_byte_rd_o(tx_rd3), .tx_byte_i(tx3),
        .rx_byte_vld_o(rx_vld3), .rx_byte_o(rx_byte3), .done_o(done3),
        .spi_sclk_o(sclk3), .spi_mosi_o(mosi3), .spi_cs_n_o(cs3),
        .spi_miso_i(miso3), .dc_o(dc3)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave/regfile model + monitor for DUT A ----------------
    logic [7:0] regfile [c_n] = '{default: 8'h00};
    logic [7:0] s_sh = 8'h00, cmd_sh = 8'h00, tmp;
    logic       p_sclk = 1'b0, p_cs_n = 1'b1, s_rd = 1'b0, s_wr = 1'b0;
    int s_bits = 0, s_out = 0, rx_idx = 0;
    int rises = 0, dc0_rises = 0, dc_bad = 0, data_ones = 0, pops = 0;
    int rxs = 0, rx_bad = 0, dones = 0, cs_falls = 0;
    int cs_fall_cyc = 0, done_cyc = 0, high_run = 0, last_high_run = 0;

    always @(negedge clk) begin
        if (cs_n) high_run++;
        if (!cs_n && p_cs_n) begin
            cs_falls++; cs_fall_cyc = cyc; last_high_run = high_run; high_run = 0;
            s_bits = 0; s_out = 0; s_rd = 1'b0; s_wr = 1'b0; rx_idx = 0; miso_r = 1'b0;
        end
        if (sclk && !p_sclk && !cs_n) begin
            rises++;
            if (!dc) begin dc0_rises++; cmd_sh = {cmd_sh[6:0], mosi}; end
            else if (mosi) data_ones++;
            if ((s_bits < 8) == dc) dc_bad++;
            s_sh = {s_sh[6:0], mosi};
            s_bits++;
            if (s_bits == 8) begin
                s_rd = (s_sh == 8'h2D);
                s_wr = (s_sh == 8'h2A);
            end else if (s_wr && (s_bits % 8 == 0) && (s_bits <= 8 * (c_n + 1))) begin
                regfile[s_bits / 8 - 2] = s_sh;
            end
        end
        // Mode-0 slave: next MISO bit is presented after each falling edge.
        if (!sclk && p_sclk && !cs_n) begin
            s_out++;
            if (s_rd && s_out >= 8 && s_out < 8 * (c_n + 1)) begin
                tmp    = regfile[(s_out - 8) / 8];
                miso_r = tmp[7 - ((s_out - 8) % 8)];
            end else begin
                miso_r = 1'b0;
            end
        end
        if (tx_rd) pops++;
        if (rx_vld) begin
            rxs++;
            if (rx_idx >= c_n || rx_byte !== regfile[rx_idx]) rx_bad++;
            rx_idx++;
        end
        if (done) begin dones++; done_cyc = cyc; end
        p_sclk = sclk;
        p_cs_n = cs_n;
    end

    // ---------------- timing monitor for DUT B ----------------
    logic p_sclk3 = 1'b0, p_cs3 = 1'b1, p_mosi3 = 1'b0, p_dc3 = 1'b0, fall_seen3 = 1'b0;
    int run3 = 0, ph_bad3 = 0, viol3 = 0, rises3 = 0;
    int cs_fall3 = 0, first_rise3 = -1, last_fall3 = 0, hold_gap3 = 0;

    always @(negedge clk) begin
        if (!cs3 && p_cs3) begin cs_fall3 = cyc; fall_seen3 = 1'b0; first_rise3 = -1; end
        if (cs3 && !p_cs3) hold_gap3 = cyc - last_fall3;
        if (sclk3 != p_sclk3) begin
            if (p_sclk3) begin
                if (run3 != 3) ph_bad3++;
                fall_seen3 = 1'b1; last_fall3 = cyc;
            end else begin
                rises3++;
                if (first_rise3 < 0) first_rise3 = cyc;
                if (fall_seen3 && run3 != 3) ph_bad3++;
                if (mosi3 != p_mosi3 || dc3 != p_dc3) viol3++;
            end
            run3 = 1;
        end else begin
            run3++;
            if (sclk3 && (mosi3 != p_mosi3 || dc3 != p_dc3)) viol3++;
        end
        p_sclk3 = sclk3; p_cs3 = cs3; p_mosi3 = mosi3; p_dc3 = dc3;
    end

    // ---------------- stimulus ----------------
    int b_rises, b_dc0, b_dcbad, b_ones, b_pops, b_rxs, b_rxbad, b_dones, b_falls;

    task automatic snap();
        b_rises = rises; b_dc0 = dc0_rises; b_dcbad = dc_bad; b_ones = data_ones;
        b_pops = pops; b_rxs = rxs; b_rxbad = rx_bad; b_dones = dones; b_falls = cs_falls;
    endtask

    task automatic issue(input logic rw);
        @(negedge clk);
        cmd_vld = 1'b1; cmd_rw = rw;
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    // Returns one cycle after done so the monitors have settled.
    task automatic wait_done(input string tag, input logic sel, input int max);
        logic seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (sel ? done3 : done) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("idle_cs_n", 32'(cs_n), 32'd1);
        check("idle_sclk", 32'(sclk), 32'd0);
        check("idle_dc", 32'(dc), 32'd0);
        check("idle_rdy", 32'(cmd_rdy), 32'd1);
        check("idle_strobes", 32'(pops + rxs + dones), 32'd0);

        // CONF_WR with payload 0x01..0x08
        snap();
        issue(1'b0);
        wait_done("wr_done", 1'b0, 400);
        check("wr_rises", 32'(rises - b_rises), 32'd72);
        check("wr_cmd", 32'(cmd_sh), 32'h2A);
        check("wr_dc0_rises", 32'(dc0_rises - b_dc0), 32'd8);
        check("wr_dc_bad", 32'(dc_bad - b_dcbad), 32'd0);
        check("wr_pops", 32'(pops - b_pops), 32'd8);
        check("wr_no_rx", 32'(rxs - b_rxs), 32'd0);
        check("wr_latency", 32'(done_cyc - cs_fall_cyc), 32'd294);
        for (int i = 0; i < c_n; i++) check("wr_regfile", 32'(regfile[i]), 32'(i + 1));

        // CONF_RD returns 0x01..0x08
        snap();
        issue(1'b1);
        wait_done("rd_done", 1'b0, 400);
        check("rd_cmd", 32'(cmd_sh), 32'h2D);
        check("rd_mosi_zero", 32'(data_ones - b_ones), 32'd0);
        check("rd_rx_count", 32'(rxs - b_rxs), 32'd8);
        check("rd_rx_data", 32'(rx_bad - b_rxbad), 32'd0);
        check("rd_no_pops", 32'(pops - b_pops), 32'd0);
        check("rd_latency", 32'(done_cyc - cs_fall_cyc), 32'd294);

        // Timing on CLK_DIV=3 instance
        @(negedge clk);
        cmd_vld3 = 1'b1;
        @(negedge clk);
        cmd_vld3 = 1'b0;
        wait_done("t3_done", 1'b1, 600);
        check("t3_rises", 32'(rises3), 32'd72);
        check("t3_phase_len", 32'(ph_bad3), 32'd0);
        check("t3_change_high", 32'(viol3), 32'd0);
        // first rise = 3-cycle setup + 3-cycle low phase
        check("t3_setup_gap", 32'(first_rise3 - cs_fall3), 32'd6);
        check("t3_hold_gap", 32'(hold_gap3), 32'd6);

        // Busy: mid-transaction request must be ignored (payload 0x09..0x10)
        snap();
        issue(1'b0);
        repeat (100) @(negedge clk);
        cmd_vld = 1'b1; cmd_rw = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        wait_done("busy_done", 1'b0, 400);
        repeat (20) @(negedge clk);
        check("busy_falls", 32'(cs_falls - b_falls), 32'd1);
        check("busy_dones", 32'(dones - b_dones), 32'd1);
        check("busy_pops", 32'(pops - b_pops), 32'd8);
        check("busy_cs_idle", 32'(cs_n), 32'd1);
        check("busy_regfile7", 32'(regfile[7]), 32'h10);

        // Back-to-back reads with cmd_vld held through done
        snap();
        @(negedge clk);
        cmd_vld = 1'b1; cmd_rw = 1'b1;
        wait_done("b2b_first", 1'b0, 400);
        cmd_vld = 1'b0;
        wait_done("b2b_second", 1'b0, 400);
        check("b2b_cs_gap", 32'(last_high_run), 32'd1);
        check("b2b_dones", 32'(dones - b_dones), 32'd2);
        check("b2b_rx_count", 32'(rxs - b_rxs), 32'd16);
        check("b2b_rx_data", 32'(rx_bad - b_rxbad), 32'd0);

        // Reset during byte 3, bit 4 of a read
        snap();
        issue(1'b1);
        repeat (143) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_dc", 32'(dc), 32'd0);
        check("rst_rdy", 32'(cmd_rdy), 32'd1);
        check("rst_rx_before", 32'(rxs - b_rxs), 32'd3);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_done", 32'(dones - b_dones), 32'd0);
        check("rst_rx_out", 32'(rx_byte), 32'd0);
        snap();
        issue(1'b1);
        wait_done("rst_next_done", 1'b0, 400);
        check("rst_next_rx", 32'(rxs - b_rxs), 32'd8);
        check("rst_next_data", 32'(rx_bad - b_rxbad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
